// File: rtl/imem_pkg.sv
// imem_pkg: shared definitions for the instruction-memory loader.
//  - IMEM_ADDR_W / IMEM_DEPTH : word-address width and depth of the target memory
//  - BYTES_PER_WORD           : stream bytes packed into one memory word
//  - load_state_t             : loader FSM state encoding
package imem_pkg;

  localparam int IMEM_ADDR_W    = 9;
  localparam int IMEM_DEPTH     = 1 << IMEM_ADDR_W;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    CSUM   = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } load_state_t;

endpackage

// File: rtl/imem_loader_word_packer.sv
// word_packer: collects stream bytes MSB first into 32-bit words.
// Ports:
//  clk, reset   clock and synchronous active-high reset
//  clear        restarts packing at byte 0 (new frame)
//  byte_en      a payload byte is consumed this cycle
//  byte_data    the payload byte
//  word_valid   high in the cycle the 4th byte of a word is consumed
//  word         the completed word, valid with word_valid
module word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  cnt_reg;
  // Only the first three bytes need storing; the fourth arrives with word_valid.
  logic [23:0] shift_reg;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_reg   <= 2'd0;
      shift_reg <= 24'd0;
    end else if (byte_en) begin
      cnt_reg   <= cnt_reg + 2'd1;
      shift_reg <= {shift_reg[15:0], byte_data};
    end
  end

  assign word_valid = byte_en && (cnt_reg == 2'd3);
  assign word       = {shift_reg, byte_data};

endmodule

// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream program loader driving the write port of the
// instruction memory. Frame = LEN_HI, LEN_LO, LEN big-endian words, CSUM, where
// CSUM is the XOR of every preceding frame byte.
// Ports:
//  clk, reset            clock, synchronous active-high reset
//  start                 begins a frame (ignored while a frame is in progress)
//  byte_valid/byte_data  incoming stream byte
//  byte_ready            loader accepts a byte this cycle
//  we/waddr/wdata        memory write port, one we pulse per word
//  busy                  frame in progress (holds the CPU in reset)
//  done / err            last frame outcome, held until the next start or reset
module imem_loader
  import imem_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = 32            // only 32 is supported
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [16:0] DEPTH_L = 17'(1 << ADDR_W);
  localparam logic [ADDR_W:0] IDX_ONE = (ADDR_W + 1)'(1);

  load_state_t        state_reg, state_next;
  logic [15:0]        len_reg;
  logic [7:0]         csum_reg;
  // One bit wider than the address so it can step past the last word.
  logic [ADDR_W:0]    word_idx_reg;
  logic               we_reg;
  logic [ADDR_W-1:0]  waddr_reg;
  logic [DATA_W-1:0]  wdata_reg;

  logic               in_frame;
  logic               start_ok;
  logic               transfer;
  logic               pack_en;
  logic               word_valid;
  logic [31:0]        word;
  logic [15:0]        len_in;
  logic               last_word;

  assign in_frame  = (state_reg == LEN_HI) || (state_reg == LEN_LO) ||
                     (state_reg == DATA)   || (state_reg == CSUM);
  assign start_ok  = start && !in_frame;
  assign transfer  = byte_valid && in_frame;
  assign pack_en   = transfer && (state_reg == DATA);
  // Length as it stands once the low byte is on the bus.
  assign len_in    = {len_reg[15:8], byte_data};
  assign last_word = (16'(word_idx_reg) == (len_reg - 16'd1));

  word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_ok),
    .byte_en    (pack_en),
    .byte_data  (byte_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE, ERR: begin
        if (start) state_next = LEN_HI;
      end
      LEN_HI: begin
        if (transfer) state_next = LEN_LO;
      end
      LEN_LO: begin
        if (transfer) begin
          if (len_in == 16'd0)             state_next = CSUM;
          else if ({1'b0, len_in} > DEPTH_L) state_next = ERR;
          else                             state_next = DATA;
        end
      end
      DATA: begin
        if (word_valid && last_word) state_next = CSUM;
      end
      CSUM: begin
        if (transfer) state_next = (byte_data == csum_reg) ? DONE : ERR;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      len_reg      <= 16'd0;
      csum_reg     <= 8'd0;
      word_idx_reg <= '0;
      we_reg       <= 1'b0;
      waddr_reg    <= '0;
      wdata_reg    <= '0;
    end else begin
      state_reg <= state_next;
      we_reg    <= word_valid;
      if (start_ok) begin
        len_reg      <= 16'd0;
        csum_reg     <= 8'd0;
        word_idx_reg <= '0;
      end
      // Running XOR covers every accepted byte; in CSUM the update is harmless
      // because the frame ends on that same byte.
      if (transfer) csum_reg <= csum_reg ^ byte_data;
      if (transfer && (state_reg == LEN_HI)) len_reg[15:8] <= byte_data;
      if (transfer && (state_reg == LEN_LO)) len_reg[7:0]  <= byte_data;
      if (word_valid) begin
        waddr_reg    <= word_idx_reg[ADDR_W-1:0];
        wdata_reg    <= DATA_W'(word);
        word_idx_reg <= word_idx_reg + IDX_ONE;
      end
    end
  end

  assign byte_ready = in_frame;
  assign busy       = in_frame;
  assign done       = (state_reg == DONE);
  assign err        = (state_reg == ERR);
  assign we         = we_reg;
  assign waddr      = waddr_reg;
  assign wdata      = wdata_reg;

endmodule
